// File: rtl/uart_framed.sv
// Full-duplex UART with compile-time frame format (5-9 data bits, none/odd/even parity, 1-2 stop bits).
// The receiver votes over three mid-bit samples and flags parity and framing errors per byte.
module uart_framed #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 460800,
    parameter int OVER_SAMP = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rxd,
    output logic                 uart_txd,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_send,
    output logic                 tx_busy,
    output logic                 data_sent,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_received,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int DIV      = CLK_FREQ / (BAUD_RATE * OVER_SAMP);
    localparam int BIT_CLKS = DIV * OVER_SAMP;
    localparam int DIVW     = $clog2(DIV) + 1;
    localparam int TICKW    = $clog2(OVER_SAMP) + 1;
    localparam int TXCW     = $clog2(BIT_CLKS) + 1;
    localparam int BCW      = 4;

    localparam logic [DIVW-1:0]  DIV_LAST    = DIVW'(DIV - 1);
    localparam logic [TICKW-1:0] OS_LAST     = TICKW'(OVER_SAMP - 1);
    localparam logic [TICKW-1:0] VOTE_S0     = TICKW'(OVER_SAMP / 2 - 1);
    localparam logic [TICKW-1:0] VOTE_S1     = TICKW'(OVER_SAMP / 2);
    localparam logic [TICKW-1:0] VOTE_S2     = TICKW'(OVER_SAMP / 2 + 1);
    localparam logic [TXCW-1:0]  TXC_LAST    = TXCW'(BIT_CLKS - 1);
    localparam logic [TXCW-1:0]  TXC_PRELAST = TXCW'(BIT_CLKS - 2);
    localparam logic [BCW-1:0]   DATA_LAST   = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0]   STOP_LAST   = BCW'(STOP_BITS - 1);

    if (DIV < 1) begin : g_bad_div
        $error("uart_framed: CLK_FREQ too low for BAUD_RATE*OVER_SAMP");
    end
    if ((OVER_SAMP < 8) || (OVER_SAMP % 2 != 0)) begin : g_bad_os
        $error("uart_framed: OVER_SAMP must be even and >= 8");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data
        $error("uart_framed: DATA_BITS must be 5..9");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_par
        $error("uart_framed: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
        $error("uart_framed: STOP_BITS must be 1 or 2");
    end

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY == 1);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;

    tx_state_e            tx_state_q;
    logic [TXCW-1:0]      tx_cnt_q;
    logic [BCW-1:0]       tx_bit_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic [DATA_BITS-1:0] tx_shift_d;
    logic                 tx_par_q;
    logic                 txd_q;
    logic                 tx_busy_q;
    logic                 data_sent_q;
    logic                 tx_bit_end_d;

    assign tx_shift_d   = tx_shift_q >> 1;
    assign tx_bit_end_d = (tx_cnt_q == TXC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_par_q    <= 1'b0;
            txd_q       <= 1'b1;
            tx_busy_q   <= 1'b0;
            data_sent_q <= 1'b0;
        end else begin
            data_sent_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (data_send) begin
                        tx_shift_q <= data_in;
                        tx_par_q   <= parity_bit(data_in);
                        txd_q      <= 1'b0;
                        tx_busy_q  <= 1'b1;
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_end_d) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        txd_q      <= tx_shift_q[0];
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end_d) begin
                        tx_cnt_q   <= '0;
                        tx_shift_q <= tx_shift_d;
                        if (tx_bit_q == DATA_LAST) begin
                            tx_bit_q <= '0;
                            if (PARITY != 0) begin
                                txd_q      <= tx_par_q;
                                tx_state_q <= TX_PAR;
                            end else begin
                                txd_q      <= 1'b1;
                                tx_state_q <= TX_STOP;
                            end
                        end else begin
                            tx_bit_q <= tx_bit_q + 1'b1;
                            txd_q    <= tx_shift_d[0];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_PAR: begin
                    if (tx_bit_end_d) begin
                        tx_cnt_q   <= '0;
                        txd_q      <= 1'b1;
                        tx_state_q <= TX_STOP;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_STOP: begin
                    // Release one clk early so a waiting request starts right as the stop bit ends.
                    if ((tx_bit_q == STOP_LAST) && (tx_cnt_q == TXC_PRELAST)) begin
                        tx_cnt_q    <= '0;
                        tx_bit_q    <= '0;
                        tx_busy_q   <= 1'b0;
                        data_sent_q <= 1'b1;
                        tx_state_q  <= TX_IDLE;
                    end else if (tx_bit_end_d) begin
                        tx_cnt_q <= '0;
                        tx_bit_q <= tx_bit_q + 1'b1;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign uart_txd  = txd_q;
    assign tx_busy   = tx_busy_q;
    assign data_sent = data_sent_q;

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_HI} rx_state_e;

    logic                 rx_meta_q;
    logic                 rxs_q;
    rx_state_e            rx_state_q;
    logic [DIVW-1:0]      rx_div_q;
    logic [TICKW-1:0]     rx_tick_q;
    logic [BCW-1:0]       rx_bit_q;
    logic                 rx_s0_q;
    logic                 rx_s1_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_perr_q;
    logic [DATA_BITS-1:0] data_out_q;
    logic                 data_received_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 rx_tick_d;
    logic                 rx_vote_d;
    logic                 rx_vote_now_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= uart_rxd;
            rxs_q     <= rx_meta_q;
        end
    end

    assign rx_tick_d     = (rx_div_q == DIV_LAST);
    assign rx_vote_d     = majority3(rx_s0_q, rx_s1_q, rxs_q);
    assign rx_vote_now_d = rx_tick_d && (rx_tick_q == VOTE_S2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q      <= RX_IDLE;
            rx_div_q        <= '0;
            rx_tick_q       <= '0;
            rx_bit_q        <= '0;
            rx_s0_q         <= 1'b1;
            rx_s1_q         <= 1'b1;
            rx_shift_q      <= '0;
            rx_perr_q       <= 1'b0;
            data_out_q      <= '0;
            data_received_q <= 1'b0;
            parity_err_q    <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            data_received_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    // Timing counters sit at zero here, so leaving IDLE is the restart on the start edge.
                    rx_div_q  <= '0;
                    rx_tick_q <= '0;
                    rx_bit_q  <= '0;
                    if (!rxs_q) rx_state_q <= RX_START;
                end
                RX_WAIT_HI: begin
                    if (rxs_q) rx_state_q <= RX_IDLE;
                end
                default: begin
                    if (rx_tick_d) begin
                        rx_div_q  <= '0;
                        rx_tick_q <= (rx_tick_q == OS_LAST) ? '0 : rx_tick_q + 1'b1;
                        if (rx_tick_q == VOTE_S0) rx_s0_q <= rxs_q;
                        if (rx_tick_q == VOTE_S1) rx_s1_q <= rxs_q;
                    end else begin
                        rx_div_q <= rx_div_q + 1'b1;
                    end
                    if (rx_vote_now_d) begin
                        case (rx_state_q)
                            RX_START: begin
                                rx_state_q <= rx_vote_d ? RX_IDLE : RX_DATA;
                            end
                            RX_DATA: begin
                                rx_shift_q <= {rx_vote_d, rx_shift_q[DATA_BITS-1:1]};
                                if (rx_bit_q == DATA_LAST) begin
                                    rx_bit_q   <= '0;
                                    rx_state_q <= (PARITY != 0) ? RX_PAR : RX_STOP;
                                end else begin
                                    rx_bit_q <= rx_bit_q + 1'b1;
                                end
                            end
                            RX_PAR: begin
                                rx_perr_q  <= (rx_vote_d != parity_bit(rx_shift_q));
                                rx_state_q <= RX_STOP;
                            end
                            RX_STOP: begin
                                data_out_q      <= rx_shift_q;
                                parity_err_q    <= rx_perr_q;
                                frame_err_q     <= !rx_vote_d;
                                data_received_q <= 1'b1;
                                rx_state_q      <= rx_vote_d ? RX_IDLE : RX_WAIT_HI;
                            end
                            default: rx_state_q <= RX_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign data_out      = data_out_q;
    assign data_received = data_received_q;
    assign parity_err    = parity_err_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_uart_framed.sv
// Directed bench for uart_framed: three instances cover 8N1 (loopback / driven line), 8E1 and 8N2.
// Bit rate is 16 clks per bit; frame cycle i of a request issued at cyc c is logged at cyc c+1+i.
module tb_uart_framed;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 8N1 instance
    logic       loop_a = 1'b1, rxd_drv_a = 1'b1, send_a = 1'b0;
    logic [7:0] din_a = 8'h00;
    logic       rxd_a, txd_a, busy_a, sent_a, rcv_a, perr_a, ferr_a;
    logic [7:0] dout_a;
    assign rxd_a = loop_a ? txd_a : rxd_drv_a;

    // 8E1 instance, loopback with an optional bit flip on the receive path
    logic       flip_b = 1'b0, send_b = 1'b0;
    logic [7:0] din_b = 8'h00;
    logic       rxd_b, txd_b, busy_b, sent_b, rcv_b, perr_b, ferr_b;
    logic [7:0] dout_b;
    assign rxd_b = txd_b ^ flip_b;

    // 8N2 instance, receive line idle
    logic       rxd_c = 1'b1, send_c = 1'b0;
    logic [7:0] din_c = 8'h00;
    logic       txd_c, busy_c, sent_c, rcv_c, perr_c, ferr_c;
    logic [7:0] dout_c;

    uart_framed #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVER_SAMP(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .rst(rst), .uart_rxd(rxd_a), .uart_txd(txd_a),
        .data_in(din_a), .data_send(send_a), .tx_busy(busy_a), .data_sent(sent_a),
        .data_out(dout_a), .data_received(rcv_a), .parity_err(perr_a), .frame_err(ferr_a));

    uart_framed #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVER_SAMP(16),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_b (
        .clk(clk), .rst(rst), .uart_rxd(rxd_b), .uart_txd(txd_b),
        .data_in(din_b), .data_send(send_b), .tx_busy(busy_b), .data_sent(sent_b),
        .data_out(dout_b), .data_received(rcv_b), .parity_err(perr_b), .frame_err(ferr_b));

    uart_framed #(.CLK_FREQ(16_000_000), .BAUD_RATE(1_000_000), .OVER_SAMP(16),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_dut_c (
        .clk(clk), .rst(rst), .uart_rxd(rxd_c), .uart_txd(txd_c),
        .data_in(din_c), .data_send(send_c), .tx_busy(busy_c), .data_sent(sent_c),
        .data_out(dout_c), .data_received(rcv_c), .parity_err(perr_c), .frame_err(ferr_c));

    // Negedge monitor: cycle counter, txd history and pulse counters
    int   cyc = 0;
    logic txd_a_log [0:4095];
    logic txd_b_log [0:4095];
    logic txd_c_log [0:4095];
    int   n_sent_a = 0, n_sent_b = 0, n_sent_c = 0;
    int   n_rcv_a = 0, n_rcv_b = 0, n_rcv_c = 0;
    int   sent_a_cyc = 0, sent_b_cyc = 0;
    int   sent_c_cyc [0:3];

    always @(negedge clk) begin
        cyc = cyc + 1;
        txd_a_log[12'(cyc)] = txd_a;
        txd_b_log[12'(cyc)] = txd_b;
        txd_c_log[12'(cyc)] = txd_c;
        if (sent_a) begin n_sent_a = n_sent_a + 1; sent_a_cyc = cyc; end
        if (sent_b) begin n_sent_b = n_sent_b + 1; sent_b_cyc = cyc; end
        if (sent_c) begin
            if (n_sent_c < 4) sent_c_cyc[n_sent_c] = cyc;
            n_sent_c = n_sent_c + 1;
        end
        if (rcv_a) n_rcv_a = n_rcv_a + 1;
        if (rcv_b) n_rcv_b = n_rcv_b + 1;
        if (rcv_c) n_rcv_c = n_rcv_c + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic txd_at(input int which, input int x);
        logic [11:0] i;
        i = 12'(x);
        case (which)
            0:       return txd_a_log[i];
            1:       return txd_b_log[i];
            default: return txd_c_log[i];
        endcase
    endfunction

    // Data byte of a frame whose first clk was logged at cyc f0 (mid-bit samples).
    function automatic logic [7:0] frame_byte(input int which, input int f0);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = txd_at(which, f0 + 16 * (k + 1) + 8);
        return b;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic req_a(input logic [7:0] d, output int c);
        din_a = d; send_a = 1'b1; c = cyc;
        wait_cyc(1);
        send_a = 1'b0;
    endtask

    task automatic req_b(input logic [7:0] d, output int c);
        din_b = d; send_b = 1'b1; c = cyc;
        wait_cyc(1);
        send_b = 1'b0;
    endtask

    task automatic drive_a(input logic v, input int n);
        rxd_drv_a = v;
        wait_cyc(n);
    endtask

    task automatic frame_a(input logic [7:0] d, input logic stop_v);
        drive_a(1'b0, 16);
        for (int k = 0; k < 8; k++) drive_a(d[k], 16);
        drive_a(stop_v, 16);
    endtask

    initial begin
        int c, r0, s0;
        logic [9:0] exp_a5;
        exp_a5 = {1'b1, 8'hA5, 1'b0};   // start, data LSB first, stop

        // Reset state
        wait_cyc(3);
        check_val("rst_txd", 32'(txd_a), 1);
        check_val("rst_busy", 32'(busy_a), 0);
        check_val("rst_sent", 32'(sent_a), 0);
        check_val("rst_dout", 32'(dout_a), 0);
        check_val("rst_rcv", 32'(rcv_a), 0);
        check_val("rst_perr", 32'(perr_a), 0);
        check_val("rst_ferr", 32'(ferr_a), 0);
        rst = 1'b0;
        wait_cyc(5);

        // 8N1 loopback of 0xA5
        r0 = n_rcv_a; s0 = n_sent_a;
        req_a(8'hA5, c);
        wait_cyc(79);
        check_val("a5_busy_mid", 32'(busy_a), 1);
        wait_cyc(100);
        for (int k = 0; k < 10; k++)
            check_val($sformatf("a5_txd_bit%0d", k), 32'(txd_at(0, c + 1 + 16 * k + 8)), 32'(exp_a5[k]));
        check_val("a5_txd_start_first_clk", 32'(txd_at(0, c + 1)), 0);
        check_val("a5_sent_delay", sent_a_cyc - c, 160);   // frame clk 159 of 160
        check_val("a5_sent_count", n_sent_a - s0, 1);
        check_val("a5_busy_end", 32'(busy_a), 0);
        check_val("a5_rcv_count", n_rcv_a - r0, 1);
        check_val("a5_dout", 32'(dout_a), 32'hA5);
        check_val("a5_perr", 32'(perr_a), 0);
        check_val("a5_ferr", 32'(ferr_a), 0);

        // Framing error on 0x3C, line held low, then recovery
        loop_a = 1'b0;
        drive_a(1'b1, 20);
        r0 = n_rcv_a;
        frame_a(8'h3C, 1'b0);
        drive_a(1'b0, 64);
        check_val("fe_rcv_count", n_rcv_a - r0, 1);
        check_val("fe_ferr", 32'(ferr_a), 1);
        check_val("fe_dout", 32'(dout_a), 32'h3C);
        check_val("fe_perr", 32'(perr_a), 0);
        drive_a(1'b1, 200);
        check_val("fe_no_extra_rcv", n_rcv_a - r0, 1);
        frame_a(8'h96, 1'b1);
        drive_a(1'b1, 20);
        check_val("fe_recover_count", n_rcv_a - r0, 2);
        check_val("fe_recover_dout", 32'(dout_a), 32'h96);
        check_val("fe_recover_ferr", 32'(ferr_a), 0);

        // 6-clk low glitch, then a clean 0x55
        r0 = n_rcv_a;
        drive_a(1'b0, 6);
        drive_a(1'b1, 40);
        check_val("gl_no_rcv", n_rcv_a - r0, 0);
        check_val("gl_dout_held", 32'(dout_a), 32'h96);
        frame_a(8'h55, 1'b1);
        drive_a(1'b1, 20);
        check_val("gl_rcv_count", n_rcv_a - r0, 1);
        check_val("gl_dout", 32'(dout_a), 32'h55);
        check_val("gl_ferr", 32'(ferr_a), 0);
        loop_a = 1'b1;
        wait_cyc(10);

        // 8E1: 0x07 has three ones, so even parity bit is 1; flip it on the receive path
        r0 = n_rcv_b;
        req_b(8'h07, c);
        wait_cyc(144);
        flip_b = 1'b1;
        wait_cyc(16);
        flip_b = 1'b0;
        wait_cyc(40);
        check_val("e1_txd_parity_07", 32'(txd_at(1, c + 1 + 152)), 1);
        check_val("e1_txd_byte_07", 32'(frame_byte(1, c + 1)), 32'h07);
        check_val("e1_sent_delay", sent_b_cyc - c, 176);
        check_val("e1_rcv_count", n_rcv_b - r0, 1);
        check_val("e1_perr_flipped", 32'(perr_b), 1);
        check_val("e1_dout_flipped", 32'(dout_b), 32'h07);
        check_val("e1_ferr_flipped", 32'(ferr_b), 0);
        // 0x03 has two ones, parity bit 0, clean
        req_b(8'h03, c);
        wait_cyc(200);
        check_val("e1_txd_parity_03", 32'(txd_at(1, c + 1 + 152)), 0);
        check_val("e1_rcv_count2", n_rcv_b - r0, 2);
        check_val("e1_perr_clean", 32'(perr_b), 0);
        check_val("e1_dout_clean", 32'(dout_b), 32'h03);

        // 8N2 back-to-back with data_send held high
        s0 = n_sent_c;
        din_c = 8'h11; send_c = 1'b1; c = cyc;
        wait_cyc(5);
        din_c = 8'h22;
        wait_cyc(175);
        send_c = 1'b0;
        wait_cyc(200);
        check_val("n2_sent_count", n_sent_c - s0, 2);
        check_val("n2_sent1_delay", sent_c_cyc[s0] - c, 176);
        check_val("n2_sent2_delay", sent_c_cyc[s0 + 1] - c, 352);
        check_val("n2_txd_last_stop_clk", 32'(txd_at(2, c + 176)), 1);
        check_val("n2_txd_start2_next_clk", 32'(txd_at(2, c + 177)), 0);
        check_val("n2_byte1", 32'(frame_byte(2, c + 1)), 32'h11);
        check_val("n2_byte2", 32'(frame_byte(2, c + 177)), 32'h22);
        check_val("n2_stop2_frame1", 32'(txd_at(2, c + 1 + 168)), 1);
        check_val("n2_stop2_frame2", 32'(txd_at(2, c + 177 + 168)), 1);
        check_val("n2_busy_end", 32'(busy_c), 0);
        check_val("n2_rx_idle_count", n_rcv_c, 0);
        check_val("n2_rx_idle_flags", {30'd0, perr_c, ferr_c}, 0);
        check_val("n2_rx_idle_dout", 32'(dout_c), 0);

        // Asynchronous reset mid-TX and mid-RX, then a fresh 0xF0 round trip
        r0 = n_rcv_a;
        req_a(8'hF0, c);
        wait_cyc(49);
        check_val("ar_busy_before", 32'(busy_a), 1);
        rst = 1'b1;
        #1;
        check_val("ar_txd", 32'(txd_a), 1);
        check_val("ar_busy", 32'(busy_a), 0);
        check_val("ar_sent", 32'(sent_a), 0);
        check_val("ar_dout", 32'(dout_a), 0);
        check_val("ar_rcv", 32'(rcv_a), 0);
        check_val("ar_perr", 32'(perr_a), 0);
        check_val("ar_ferr", 32'(ferr_a), 0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(5);
        check_val("ar_no_rcv_from_aborted", n_rcv_a - r0, 0);
        req_a(8'hF0, c);
        wait_cyc(200);
        check_val("ar_rcv_count", n_rcv_a - r0, 1);
        check_val("ar_dout_f0", 32'(dout_a), 32'hF0);
        check_val("ar_ferr_f0", 32'(ferr_a), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
